vblg14x12_sdpram: RTL and testbench
===================================

// Module: vblg14x12_sdpram
// PURPOSE
// - Simple dual-port block RAM, 256 words x 14 bits: one write port, one read port.
// - Single clock domain, used as a line/sample buffer in the audio processing datapath.
// - Write is synchronous. Read is synchronous with a registered output, latency 1 (2 with OUTPUT_REG).
// PARAMETERS
// - ADDR_WIDTH   8   write/read address width; depth = 2**ADDR_WIDTH = 256
// - DATA_WIDTH   14  write/read data width (same width on both ports)
// - OUTPUT_REG   0   1 = extra output pipeline register; read latency becomes 2
// PORTS
// - clk      in   1           single clock for both ports, rising-edge active
// - rst_n    in   1           asynchronous active-low reset; clears output registers only
// - wr_en    in   1           write enable, sampled at posedge clk
// - wr_addr  in   ADDR_WIDTH  write address
// - wr_data  in   DATA_WIDTH  write data
// - rd_addr  in   ADDR_WIDTH  read address, sampled every posedge clk (no read enable)
// - rd_data  out  DATA_WIDTH  read data, registered
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low.
// - Reset (rst_n=0, asynchronous assert):
//   - rd_data and any internal pipeline register go to 0 immediately.
//   - Memory array contents are NOT cleared.
//   - Writes are ignored while rst_n=0.
//   - Release is synchronous to the next posedge clk.
// - Memory contents after power-up are undefined (X in simulation); there is no init file.
// - Write: at posedge clk with rst_n=1 and wr_en=1, mem[wr_addr] <= wr_data. With wr_en=0, memory is unchanged.
// - Read, OUTPUT_REG=0: at every posedge clk with rst_n=1, rd_data <= mem[rd_addr]. Data is valid one cycle after the address is presented.
// - Read, OUTPUT_REG=1:
//   - stage1 <= mem[rd_addr]; rd_data <= stage1.
//   - Latency is 2 cycles; both stages are reset to 0.
// - Read-during-write to the same address in the same cycle returns the OLD contents (read-before-write). The new data is visible on the next read.
// - Addresses are full range 0..255, with no wrap logic inside the block. Callers driving wider counters pass only the low ADDR_WIDTH bits, so 256 aliases to 0.
// - No read enable and no output clock enable: rd_data tracks rd_addr every cycle.
// - No byte enables, no address strobes, no power-save modes.
// - Global reset: simulation requires a GTP_GRS instance with GRS_N tied high.
// TESTING
// - Reset: hold rst_n=0 for 200 ns -> rd_data=0; then release rst_n and leave wr_en=0 -> memory contents unaffected by the reset.
// - Fill pass: wr_addr steps 1,2,...,255,0 on consecutive cycles with wr_data starting at 0x3FFF and decrementing by 1 per write -> mem[1]=0x3FFF, mem[255]=0x3F01, mem[0]=0x3F00.
// - Readback pass: rd_addr steps 1..255,0 on consecutive cycles -> rd_data one cycle later = 0x3FFF, 0x3FFE, ... 0x3F00. A mismatch counter must stay 0.
// - Read-during-write: write 0x1234 to address 5 while reading address 5 in the same cycle -> rd_data = old value; read of address 5 on the next cycle -> 0x1234.
// - wr_en=0 with wr_addr=7 and wr_data=0x0AAA -> mem[7] unchanged on readback.
// - OUTPUT_REG=1: repeat the readback pass -> identical data sequence delayed by 2 cycles. Assert rst_n=0 mid-read -> rd_data=0 at once, without waiting for a clock edge.

Source files
------------

// File: rtl/vblg14x12_sdpram_if.sv
// Port bundle for the simple dual-port sample buffer: one write port and one read port.
// The master drives addresses and write data. The slave (the RAM) returns rd_data.
interface vblg14x12_sdpram_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 14
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/vblg14x12_sdpram.sv
// Simple dual-port block RAM (256 x 14) used as the audio line/sample buffer.
// Reads are read-before-write. An optional second output register gives a read latency of 2.
module vblg14x12_sdpram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 14,
    parameter bit OUTPUT_REG = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vblg14x12_sdpram_if.slave     bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] stage1_reg;

    // The array has no reset so that it maps onto block RAM.
    // rst_n only blocks writes while it is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Non-blocking update ordering gives old data on a same-address read/write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_reg <= '0;
        end else begin
            stage1_reg <= mem[bus.rd_addr];
        end
    end

    generate
        if (OUTPUT_REG) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg <= '0;
                end else begin
                    out_reg <= stage1_reg;
                end
            end

            assign bus.rd_data = out_reg;
        end else begin : g_no_out_reg
            assign bus.rd_data = stage1_reg;
        end
    endgenerate
endmodule

// File: tb/tb_vblg14x12_sdpram.sv
// Directed bench: drives one RAM without the output register and one with it, using identical stimulus.
// Covers reset, the fill/readback passes, read-during-write, a blocked write, and asynchronous reset.
module tb_vblg14x12_sdpram;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    vblg14x12_sdpram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(14)) bus0 ();
    vblg14x12_sdpram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(14)) bus1 ();

    vblg14x12_sdpram #(.ADDR_WIDTH(8), .DATA_WIDTH(14), .OUTPUT_REG(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    vblg14x12_sdpram #(.ADDR_WIDTH(8), .DATA_WIDTH(14), .OUTPUT_REG(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Drive both ports identically so that the two latency variants see the same traffic.
    task automatic drive(input logic we, input logic [7:0] wa, input logic [13:0] wd, input logic [7:0] ra);
        bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd; bus0.rd_addr = ra;
        bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd; bus1.rd_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contents left by the fill pass.
    function automatic logic [13:0] fill_val(input logic [7:0] a);
        logic [13:0] v;
        if (a == 8'd0) v = 14'h3F00;
        else           v = 14'h3FFF - 14'(a) + 14'd1;
        return v;
    endfunction

    initial begin
        logic [7:0]  addr;
        logic [13:0] prev_exp;
        tests_run    = 0;
        tests_failed = 0;

        // Reset is held for 200 ns. A write attempted during reset must be ignored.
        rst_n = 1'b0;
        drive(1'b1, 8'd9, 14'h0111, 8'd0);
        #200;
        check_eq("reset_rd0", bus0.rd_data, 14'h0000);
        check_eq("reset_rd1", bus1.rd_data, 14'h0000);
        drive(1'b0, 8'd0, 14'h0000, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fill pass: addresses 1..255,0 take the data 0x3FFF downward.
        for (int i = 0; i < 256; i++) begin
            addr = 8'(i + 1);
            drive(1'b1, addr, 14'h3FFF - 14'(i), 8'd0);
            tick();
        end
        drive(1'b0, 8'd0, 14'h0000, 8'd1);

        // Readback pass. dut0 lags the address by one cycle and dut1 by two.
        prev_exp = 14'h0;
        for (int i = 0; i < 256; i++) begin
            addr = 8'(i + 1);
            bus0.rd_addr = addr;
            bus1.rd_addr = addr;
            tick();
            check_eq("rb_lat1", bus0.rd_data, fill_val(addr));
            if (i > 0) check_eq("rb_lat2", bus1.rd_data, prev_exp);
            prev_exp = fill_val(addr);
        end
        tick();
        check_eq("rb_lat2_last", bus1.rd_data, 14'h3F00);

        // Read-during-write on address 5 returns the old value first, then the new value.
        drive(1'b1, 8'd5, 14'h1234, 8'd5);
        tick();
        check_eq("rdw_old0", bus0.rd_data, 14'h3FFB);
        drive(1'b0, 8'd5, 14'h1234, 8'd5);
        tick();
        check_eq("rdw_new0", bus0.rd_data, 14'h1234);
        check_eq("rdw_old1", bus1.rd_data, 14'h3FFB);
        tick();
        check_eq("rdw_new1", bus1.rd_data, 14'h1234);

        // A write with wr_en low must leave mem[7] unchanged.
        drive(1'b0, 8'd7, 14'h0AAA, 8'd7);
        tick();
        tick();
        check_eq("noen_rd0", bus0.rd_data, 14'h3FF9);
        check_eq("noen_rd1", bus1.rd_data, 14'h3FF9);

        // Asynchronous reset in the middle of a read clears the outputs without waiting for a clock edge.
        drive(1'b0, 8'd0, 14'h0000, 8'd10);
        tick();
        tick();
        check_eq("pre_rst_rd1", bus1.rd_data, 14'h3FF6);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst0", bus0.rd_data, 14'h0000);
        check_eq("async_rst1", bus1.rd_data, 14'h0000);
        drive(1'b1, 8'd3, 14'h0555, 8'd10);
        tick();
        tick();
        check_eq("in_rst_rd1", bus1.rd_data, 14'h0000);
        drive(1'b0, 8'd0, 14'h0000, 8'd3);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_rd0", bus0.rd_data, 14'h3FFD);
        tick();
        check_eq("post_rst_rd1", bus1.rd_data, 14'h3FFD);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
